// File: rtl/stepper_axis_driver.sv
// STEP/DIR generator for one stepper axis: latches a step period and direction at each
// step start, sequences SETUP/PULSE/LOW timing and tracks the signed axis position.
module stepper_axis_driver #(
  parameter int unsigned SETTLE_CYCLES = 50,
  parameter int unsigned PULSE_CYCLES  = 100,
  parameter int unsigned MIN_PERIOD    = 400
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic [31:0] speed,
  input  logic [31:0] direction,
  input  logic        enable,
  input  logic        zero_pos,
  output logic        step,
  output logic        dir,
  output logic [31:0] position,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StLow} state_t;

  localparam logic [31:0] SettleLast = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] PulseLast  = 32'(SETTLE_CYCLES + PULSE_CYCLES - 1);
  localparam logic [31:0] MinPeriod  = 32'(MIN_PERIOD);

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] effPeriod;
  logic        armed;
  logic        periodEnd;
  logic        canStart;
  logic [31:0] nextPeriod;
  logic        unusedDirBits;

  assign unusedDirBits = ^direction[31:1];

  always_comb begin
    periodEnd  = (state == StLow) && (cnt == effPeriod - 32'd1);
    // armed keeps the first edge after reset release from starting a step
    canStart   = ((state == StIdle) || periodEnd) && armed && enable && (speed != 32'd0);
    nextPeriod = (speed < MinPeriod) ? MinPeriod : speed;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state     <= StIdle;
      cnt       <= 32'd0;
      effPeriod <= 32'd0;
      armed     <= 1'b0;
      step      <= 1'b0;
      dir       <= 1'b0;
      busy      <= 1'b0;
      position  <= 32'd0;
    end else begin
      armed <= 1'b1;

      // A clear wins over the count of a step entering PULSE on the same edge
      if (zero_pos) begin
        position <= 32'd0;
      end else if ((state == StSetup) && (cnt == SettleLast)) begin
        position <= dir ? position + 32'd1 : position - 32'd1;
      end

      if (canStart) begin
        state     <= StSetup;
        cnt       <= 32'd0;
        effPeriod <= nextPeriod;
        dir       <= direction[0];
        busy      <= 1'b1;
        step      <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            cnt  <= 32'd0;
            step <= 1'b0;
          end
          StSetup: begin
            cnt <= cnt + 32'd1;
            if (cnt == SettleLast) begin
              state <= StPulse;
              step  <= 1'b1;
            end
          end
          StPulse: begin
            cnt <= cnt + 32'd1;
            if (cnt == PulseLast) begin
              state <= StLow;
              step  <= 1'b0;
            end
          end
          StLow: begin
            if (periodEnd) begin
              state <= StIdle;
              cnt   <= 32'd0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/stepper_axis_driver.md
Name: stepper_axis_driver

Overview:
- Downstream consumer of the register file's motion outputs. One instance per axis: the X axis is driven by xSpeed/xDirection, and the Y axis by ySpeed/yDirection.
- Converts a programmed step period and direction into stepper-driver STEP/DIR signals with guaranteed setup and pulse-width timing.
- Maintains the signed axis position counter. This counter is fed back to the register file as currentX/currentY, which the register file captures every cycle.

Parameters:
- SETTLE_CYCLES, 50, cycles DIR is held stable before STEP rises.
- PULSE_CYCLES, 100, cycles STEP is held high.
- MIN_PERIOD, 400, minimum step period in cycles. Must be >= SETTLE_CYCLES+PULSE_CYCLES+1.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- ctrl_reset  in  1  reset, asynchronous, active-low (0 = reset asserted).
- speed  in  32  step period in clock cycles, unsigned; 0 = stop.
- direction  in  32  bit0: 1 = positive (count up), 0 = negative; bits 31:1 ignored.
- enable  in  1  motion enable; 0 = finish the current step, then idle.
- zero_pos  in  1  synchronous position clear (BTNC-derived, already synchronised upstream).
- step  out  1  STEP pulse to the motor driver.
- dir  out  1  DIR level to the motor driver.
- position  out  32  signed two's-complement axis position in steps.
- busy  out  1  high while a step period is in progress.

Behaviour:
- Reset (ctrl_reset=0, asynchronous): state=IDLE, step=0, dir=0, position=0, busy=0, phase counter=0, latched period=0.
- FSM states: IDLE, SETUP, PULSE, LOW. A single phase counter cnt runs from 0 to eff_period-1 across SETUP, PULSE and LOW.
- Effective period is computed only at a step start: eff_period = (speed < MIN_PERIOD) ? MIN_PERIOD : speed.
  - Comparison is 32-bit unsigned.
  - speed, direction[0] and eff_period are latched at step start.
  - Changes to speed or direction mid-step have no effect until the next step start.
- Step start condition: in IDLE, or on the last LOW cycle, with enable=1 and speed!=0.
  - Next state is SETUP with cnt=0.
  - dir takes the latched direction[0] on that edge.
  - busy=1.
- SETUP: step=0.
  - Leaves SETUP when cnt==SETTLE_CYCLES-1; next state PULSE.
- PULSE: step=1 for exactly PULSE_CYCLES cycles.
  - On the PULSE entry edge, position updates by +1 if dir=1 or -1 if dir=0.
  - Leaves PULSE when cnt==SETTLE_CYCLES+PULSE_CYCLES-1; next state LOW.
- LOW: step=0.
  - Leaves LOW when cnt==eff_period-1.
  - Goes back to SETUP if the step start condition holds, else to IDLE with busy=0.
- Timing guarantees:
  - Back-to-back step rising edges are exactly eff_period cycles apart.
  - step, dir and busy are registered outputs with no combinational path from inputs.
- dir changes only on a step-start edge, never in PULSE or LOW.
- enable deasserted mid-step: the current step completes in full with no truncated pulse; the FSM then goes to IDLE.
- speed=0 in IDLE: stay in IDLE, step=0, dir holds its last value.
- zero_pos=1: position is set to 0 on that edge.
  - zero_pos has priority over a same-edge increment or decrement; the step is still issued on the STEP pin but not counted.
  - The FSM is unaffected.
- Position arithmetic is 32-bit modular:
  - 0x7FFFFFFF + 1 wraps to 0x80000000.
  - 0x80000000 - 1 wraps to 0x7FFFFFFF.
- Reset asserted mid-PULSE: step drops to 0 immediately (asynchronous) and all state returns to its reset values.
- Reset deassertion takes effect on the next rising clock edge; no step starts on that edge.

Test Plan:
(Parameter overrides for all scenarios: SETTLE_CYCLES=2, PULSE_CYCLES=3, MIN_PERIOD=8.)
- Reset, then speed=10, direction=1, enable=1 held for 35 cycles.
  - Required: step rises 3 cycles after start (1 start edge + 2 SETTLE) and is high for 3 cycles.
  - Rising edges are 10 cycles apart; position counts 1,2,3,4; dir=1 throughout.
- speed=3 (below MIN_PERIOD), direction=0, enable=1.
  - Required: step period is 8 cycles.
  - position goes 0 → -1 (0xFFFFFFFF) → -2; dir=0.
- Running at speed=10, direction=1; mid-PULSE set direction=0, speed=20, enable=0.
  - Required: current pulse completes its full 3 cycles and position +1.
  - Then IDLE, busy=0, dir stays 1, no further steps.
- Position preloaded to 0x7FFFFFFF via steps; one more positive step.
  - Required: position=0x80000000.
  - Then zero_pos=1 on the same edge as the next PULSE entry: position=0 and the step pulse still appears.
- ctrl_reset=0 while step=1.
  - Required: step=0 and position=0 in the same cycle without a clock edge, state IDLE.
  - After release with speed=10, enable=1, the first step rises 3 cycles after the first post-reset start edge.
- speed=0, enable=1 for 20 cycles.
  - Required: step stays 0, busy=0, position unchanged.
